md_hazard_ctrl: RTL and testbench

//  Pipeline stall controller plus HI/LO multiply/divide sequencer for the 5-stage core.

---
 rtl/md_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_md_hazard_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/md_hazard_ctrl.sv
// Stall controller for the 5-stage core: load-use, ID-stage branch operand and MD-busy hazards,
// plus the IDLE/BUSY/DONE sequencer that times the multi-cycle multiply/divide unit.
module md_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_ID,
    input  logic [31:0] Instr_EX,
    input  logic [31:0] Instr_M,
    input  logic        ID_use_rs,
    input  logic        ID_use_rt,
    input  logic        ID_branch,
    input  logic        ID_md,
    input  logic        EX_cal_r,
    input  logic        EX_cal_i,
    input  logic        EX_load,
    input  logic        M_load,
    input  logic [1:0]  md_op_EX,
    output logic        stall,
    output logic        flush_ID_EX,
    output logic        md_start,
    output logic        md_busy,
    output logic        hilo_we,
    output logic [1:0]  stall_cause,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [31:0]      CNT_MAX = 32'hFFFF_FFFF;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        stall_cnt_q, stall_cnt_d;

    logic [4:0] rs_id, rt_id, ex_dst, m_dst;
    logic       ex_writes, ex_hit, m_hit;
    logic       hz_load, hz_br, hz_md, md_req;

    // Instruction fields not involved in hazard detection.
    logic unused_fields;
    assign unused_fields = ^{Instr_ID[31:26], Instr_ID[15:0], Instr_EX[31:26], Instr_EX[10:0],
                             Instr_M[31:21], Instr_M[15:0]};

    assign rs_id     = Instr_ID[25:21];
    assign rt_id     = Instr_ID[20:16];
    assign ex_writes = EX_cal_r | EX_cal_i | EX_load;
    assign ex_dst    = EX_cal_r ? Instr_EX[15:11] : ((EX_cal_i | EX_load) ? Instr_EX[20:16] : 5'd0);
    assign m_dst     = M_load ? Instr_M[20:16] : 5'd0;

    assign ex_hit = (ID_use_rs && rs_id == ex_dst) || (ID_use_rt && rt_id == ex_dst);
    assign m_hit  = (ID_use_rs && rs_id == m_dst)  || (ID_use_rt && rt_id == m_dst);

    assign hz_load = EX_load && (ex_dst != 5'd0) && ex_hit;
    assign hz_br   = ID_branch && (((ex_dst != 5'd0) && ex_writes && ex_hit) ||
                                   ((m_dst != 5'd0) && m_hit));
    assign hz_md   = ID_md && (md_busy || md_start);

    assign md_req  = (md_op_EX == 2'b01) || (md_op_EX == 2'b10);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_start = 1'b0;
        md_busy  = 1'b0;
        hilo_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_req && reset) begin
                    md_start = 1'b1;
                    cnt_d    = (md_op_EX == 2'b10) ? DIV_LD : MULT_LD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                md_busy = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A back-to-back MD op may launch in the same cycle the previous result retires.
                hilo_we = 1'b1;
                if (md_req && reset) begin
                    md_start = 1'b1;
                    cnt_d    = (md_op_EX == 2'b10) ? DIV_LD : MULT_LD;
                    state_d  = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall       = hz_load | hz_br | hz_md;
        flush_ID_EX = stall;
        if (hz_load) begin
            stall_cause = 2'b01;
        end else if (hz_br) begin
            stall_cause = 2'b10;
        end else if (hz_md) begin
            stall_cause = 2'b11;
        end else begin
            stall_cause = 2'b00;
        end
        stall_cnt_d = (stall && stall_cnt_q != CNT_MAX) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Bench for md_hazard_ctrl: a table of single-cycle hazard vectors, then hand-written MD
// sequencing, back-to-back MD, stall counter saturation and reset-during-BUSY sequences.
module tb_md_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_ID, Instr_EX, Instr_M;
    logic        ID_use_rs, ID_use_rt, ID_branch, ID_md;
    logic        EX_cal_r, EX_cal_i, EX_load, M_load;
    logic [1:0]  md_op_EX;
    logic        stall, flush_ID_EX, md_start, md_busy, hilo_we;
    logic [1:0]  stall_cause;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    md_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .Instr_ID(Instr_ID), .Instr_EX(Instr_EX), .Instr_M(Instr_M),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_branch(ID_branch), .ID_md(ID_md),
        .EX_cal_r(EX_cal_r), .EX_cal_i(EX_cal_i), .EX_load(EX_load), .M_load(M_load),
        .md_op_EX(md_op_EX),
        .stall(stall), .flush_ID_EX(flush_ID_EX), .md_start(md_start), .md_busy(md_busy),
        .hilo_we(hilo_we), .stall_cause(stall_cause), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic       use_rs, use_rt, br, md;
        logic [4:0] ex_rd, ex_rt;
        logic       cal_r, cal_i, ex_ld;
        logic [4:0] m_rt;
        logic       m_ld;
        logic [1:0] op;
        logic       e_stall;
        logic [1:0] e_cause;
    } vec_t;

    typedef struct {
        logic       stall;
        logic [1:0] cause;
        logic       start, busy, we;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        tbl[16];
    int          checks = 0;
    int          failures = 0;
    int          step_no = 0;
    logic [31:0] exp_cnt = 32'd0;

    function automatic vec_t mk(input int rs, input int rt, input int urs, input int urt,
                                input int br, input int md, input int exrd, input int exrt,
                                input int cr, input int ci, input int el, input int mrt,
                                input int ml, input int op, input int es, input int ec);
        vec_t v;
        v.id_rs = 5'(rs);   v.id_rt = 5'(rt);
        v.use_rs = 1'(urs); v.use_rt = 1'(urt); v.br = 1'(br); v.md = 1'(md);
        v.ex_rd = 5'(exrd); v.ex_rt = 5'(exrt);
        v.cal_r = 1'(cr);   v.cal_i = 1'(ci);   v.ex_ld = 1'(el);
        v.m_rt = 5'(mrt);   v.m_ld = 1'(ml);    v.op = 2'(op);
        v.e_stall = 1'(es); v.e_cause = 2'(ec);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Instr_ID  = {6'd0, v.id_rs, v.id_rt, 16'd0};
        Instr_EX  = {6'd0, 5'd0, v.ex_rt, v.ex_rd, 11'd0};
        Instr_M   = {11'd0, v.m_rt, 16'd0};
        ID_use_rs = v.use_rs; ID_use_rt = v.use_rt; ID_branch = v.br; ID_md = v.md;
        EX_cal_r  = v.cal_r;  EX_cal_i  = v.cal_i;  EX_load = v.ex_ld; M_load = v.m_ld;
        md_op_EX  = v.op;
    endtask

    task automatic md_in(input logic [1:0] op, input logic id_md);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        md_op_EX = op;
        ID_md    = id_md;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", nm, step_no, act, exp_v);
        end
    endtask

    // Push expectations for the cycle just driven, compare mid-cycle, then advance one clock.
    task automatic apply(input logic es, input logic [1:0] ec, input logic est,
                         input logic eb, input logic ew);
        exp_t e;
        e.stall = es; e.cause = ec; e.start = est; e.busy = eb; e.we = ew; e.cnt = exp_cnt;
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        chk("stall",       32'(stall),       32'(e.stall));
        chk("flush_ID_EX", 32'(flush_ID_EX), 32'(e.stall));
        chk("stall_cause", 32'(stall_cause), 32'(e.cause));
        chk("md_start",    32'(md_start),    32'(e.start));
        chk("md_busy",     32'(md_busy),     32'(e.busy));
        chk("hilo_we",     32'(hilo_we),     32'(e.we));
        chk("stall_cnt",   stall_cnt,        e.cnt);
        $display("step %0d: stall=%0b cause=%0d start=%0b busy=%0b we=%0b cnt=%h",
                 step_no, stall, stall_cause, md_start, md_busy, hilo_we, stall_cnt);
        @(posedge clk);
        if (!reset) exp_cnt = 32'd0;
        else if (es && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        #1;
        step_no++;
    endtask

    initial begin
        //            rs rt urs urt br md exrd exrt cr ci el mrt ml op es ec
        tbl[0]  = mk(1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1);
        tbl[1]  = mk(1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(3, 4, 1, 1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 2);
        tbl[4]  = mk(3, 4, 1, 1, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(8, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 1, 2);
        tbl[6]  = mk(8, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        tbl[7]  = mk(6, 7, 1, 0, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(7, 2, 1, 1, 1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 1, 1);
        tbl[9]  = mk(9, 1, 1, 0, 1, 0, 0, 9, 0, 1, 0, 0, 0, 0, 1, 2);
        tbl[10] = mk(3, 0, 1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(2, 3, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        tbl[12] = mk(4, 4, 1, 1, 1, 0, 0, 4, 0, 0, 0, 4, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[14] = mk(5, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 6, 1, 0, 1, 2);
        tbl[15] = mk(1, 4, 1, 1, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 1);

        reset = 1'b0;
        md_in(2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Held in reset with an MD op in EX: md_start must stay low, counters at zero.
        md_in(2'b01, 1'b1);
        apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            apply(tbl[i].e_stall, tbl[i].e_cause, 1'b0, 1'b0, 1'b0);
        end
        md_in(2'b00, 1'b0);
        apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        // mult in EX with mflo in ID: start@0, busy@1-5, hilo_we@6, stall@0-5.
        md_in(2'b01, 1'b1);
        apply(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            md_in(2'b00, 1'b1);
            apply(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
        end
        md_in(2'b00, 1'b0);
        apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        // div enters EX in the DONE cycle of a mult: hilo_we and md_start together.
        md_in(2'b01, 1'b1);
        apply(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            md_in(2'b00, 1'b1);
            apply(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
        end
        md_in(2'b10, 1'b0);
        apply(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            md_in(2'b00, 1'b0);
            apply(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        end
        apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        // Stall counter saturation with a persistent load-use hazard.
        drive(tbl[0]);
        dut.stall_cnt_q = 32'hFFFF_FFFD;
        exp_cnt = 32'hFFFF_FFFD;
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        end

        // Reset while BUSY with cnt==3 aborts the op: no hilo_we afterwards.
        md_in(2'b01, 1'b0);
        apply(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        md_in(2'b00, 1'b0);
        apply(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        apply(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
